// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//   Integer register file at the write-back end of the mem_wb pipeline
//   register. One synchronous write port fed by wb_rd_*, two combinational
//   read ports serving the id stage, plus a committed-write counter and the PC
//   of the last committed write for debug/trace. Entry x0 always reads zero.
//
//   Build option: define REGFILE_BYPASS_EN to forward the write-port data to
//   a read port that addresses the register being written in the same cycle.
//   Without it, reads return the stored value and a write shows up the cycle
//   after its edge.
//
// Ports
//   clk        in   clock, all state changes on posedge
//   rst        in   synchronous active-high reset (clears entries, counter, PC)
//   we         in   write enable
//   waddr      in   write index
//   wdata      in   write data
//   wb_pc      in   PC of the instruction in write-back
//   re1/re2    in   read port enables
//   raddr1/2   in   read port indices
//   rdata1/2   out  read port data (combinational)
//   wb_cnt     out  number of committed writes (wraps)
//   last_wb_pc out  wb_pc of the most recent committed write
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic [PC_W-1:0]   last_wb_pc
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [CNT_W-1:0]  r_wb_cnt;
  logic [PC_W-1:0]   r_last_wb_pc;

  logic w_commit;
  logic w_byp1;
  logic w_byp2;

  // Writes aimed at x0 are discarded entirely, including the trace state.
  assign w_commit = we && (waddr != '0);

  // Read port value: zero under reset, when disabled, or for x0; otherwise
  // either the in-flight write data (bypass hit) or the stored entry.
  function automatic logic [DATA_W-1:0] f_read(
    input logic              i_rst,
    input logic              i_re,
    input logic [ADDR_W-1:0] i_raddr,
    input logic              i_byp,
    input logic [DATA_W-1:0] i_wdata,
    input logic [DATA_W-1:0] i_stored
  );
    logic [DATA_W-1:0] v;
    if (i_rst || !i_re || (i_raddr == '0)) v = '0;
    else if (i_byp)                        v = i_wdata;
    else                                   v = i_stored;
    return v;
  endfunction

`ifdef REGFILE_BYPASS_EN
  // Same-cycle write-through closes the WB->ID hazard without a stall.
  assign w_byp1 = we && (raddr1 == waddr);
  assign w_byp2 = we && (raddr2 == waddr);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_wb_cnt     <= '0;
      r_last_wb_pc <= '0;
    end else if (w_commit) begin
      r_regs[waddr] <= wdata;
      r_wb_cnt      <= r_wb_cnt + CNT_W'(1);
      r_last_wb_pc  <= wb_pc;
    end
  end

  assign rdata1     = f_read(rst, re1, raddr1, w_byp1, wdata, r_regs[raddr1]);
  assign rdata2     = f_read(rst, re2, raddr2, w_byp2, wdata, r_regs[raddr2]);
  assign wb_cnt     = r_wb_cnt;
  assign last_wb_pc = r_last_wb_pc;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, we, re1, re2;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, wb_pc;
  logic [31:0] rdata1, rdata2, wb_cnt, last_wb_pc;
  logic [31:0] rdata1_n, rdata2_n, last_wb_pc_n;
  logic [3:0]  wb_cnt_n;

  always #5 clk = ~clk;

  regfile #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wb_pc(wb_pc),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .wb_cnt(wb_cnt), .last_wb_pc(last_wb_pc)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap behaviour.
  regfile #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wb_pc(wb_pc),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_n),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_n),
    .wb_cnt(wb_cnt_n), .last_wb_pc(last_wb_pc_n)
  );

  // Reference model: architectural register contents and trace state.
  logic [31:0] mreg [32];
  logic [31:0] mcnt;
  logic [31:0] mpc;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic e, input logic [4:0] a);
    if (rst || !e || a == 5'd0) return 32'h0;
    if (BYP && we && a == waddr) return wdata;
    return mreg[a];
  endfunction

  // Apply inputs just after a posedge, then wait for the negedge to sample.
  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] pc,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd; wb_pc = pc;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    @(negedge clk);
  endtask

  // Advance through the posedge and apply the architectural update rules.
  task automatic commit();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      mcnt = 32'h0;
      mpc  = 32'h0;
    end else if (we && waddr != 5'd0) begin
      mreg[waddr] = wdata;
      mcnt = mcnt + 32'd1;
      mpc  = wb_pc;
    end
    #1;
  endtask

  task automatic chk_model();
    chk("rnd_rdata1",  rdata1, m_read(re1, raddr1));
    chk("rnd_rdata2",  rdata2, m_read(re2, raddr2));
    chk("rnd_wb_cnt",  wb_cnt, mcnt);
    chk("rnd_cnt4",    {28'h0, wb_cnt_n}, mcnt & 32'hF);
    chk("rnd_last_pc", last_wb_pc, mpc);
    chk("rnd_n_rdata1", rdata1_n, m_read(re1, raddr1));
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        e1;
    logic [4:0]  a1;
    logic        e2;
    logic [4:0]  a2;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] xc;
    logic [31:0] xp;
  } vec_t;

  localparam logic [31:0] RAW_EXP = BYP ? 32'h2 : 32'h1;

  vec_t tbl [15];

  initial begin
    // Expected outputs are those seen during the row's cycle (before its edge).
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        32'h0,        32'd0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h40,  1'b0, 5'd5, 1'b0, 5'd0, 32'h0,        32'h0,        32'd0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 5'd5, 1'b1, 5'd5, 32'h0,        32'h0,        32'd1, 32'h40};
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 5'd5, 1'b0, 5'd0, 32'h0,        32'h0,        32'd0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 5'd3, 32'h12345678, 32'h100, 1'b0, 5'd3, 1'b0, 5'd0, 32'h0,        32'h0,        32'd0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 5'd3, 1'b0, 5'd0, 32'h12345678, 32'h0,        32'd1, 32'h100};
    tbl[6]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h200, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0,        32'h0,        32'd1, 32'h100};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 5'd0, 1'b1, 5'd3, 32'h0,        32'h12345678, 32'd1, 32'h100};
    tbl[8]  = '{1'b0, 1'b1, 5'd7, 32'h1,        32'h300, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'd1, 32'h100};
    tbl[9]  = '{1'b0, 1'b1, 5'd7, 32'h2,        32'h304, 1'b1, 5'd7, 1'b0, 5'd7, RAW_EXP,      32'h0,        32'd2, 32'h300};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 5'd7, 1'b1, 5'd7, 32'h2,        32'h2,        32'd3, 32'h304};
    tbl[11] = '{1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 32'h400, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        32'd3, 32'h304};
    tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        32'h0,   1'b0, 5'd9, 1'b1, 5'd9, 32'h0,        32'hA5A5A5A5, 32'd4, 32'h400};
    tbl[13] = '{1'b1, 1'b1, 5'd4, 32'h55,       32'h500, 1'b0, 5'd4, 1'b0, 5'd0, 32'h0,        32'h0,        32'd4, 32'h400};
    tbl[14] = '{1'b0, 1'b0, 5'd0, 32'h0,        32'h0,   1'b1, 5'd4, 1'b1, 5'd9, 32'h0,        32'h0,        32'd0, 32'h0};

    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mcnt = 32'h0;
    mpc  = 32'h0;

    // Initial reset to bring the design out of an unknown state.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    commit();

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].pc,
            tbl[i].e1, tbl[i].a1, tbl[i].e2, tbl[i].a2);
      chk($sformatf("tbl%0d_rdata1", i), rdata1, tbl[i].x1);
      chk($sformatf("tbl%0d_rdata2", i), rdata2, tbl[i].x2);
      chk($sformatf("tbl%0d_wb_cnt", i), wb_cnt, tbl[i].xc);
      chk($sformatf("tbl%0d_cnt4", i), {28'h0, wb_cnt_n}, tbl[i].xc & 32'hF);
      chk($sformatf("tbl%0d_last_pc", i), last_wb_pc, tbl[i].xp);
      commit();
    end

    // Counter wrap: 16 committed writes from reset, interleaved with x0 writes.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    commit();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 5'(k + 1), 32'h1000 + 32'(k), 32'h800 + 32'(4 * k), 1'b0, 5'd0, 1'b0, 5'd0);
      commit();
      drive(1'b0, 1'b1, 5'd0, 32'hFFFF0000, 32'hBAD, 1'b0, 5'd0, 1'b0, 5'd0);
      commit();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd16, 1'b1, 5'd1);
    chk("wrap_cnt4",    {28'h0, wb_cnt_n}, 32'h0);
    chk("wrap_cnt32",   wb_cnt, 32'd16);
    chk("wrap_last_pc", last_wb_pc, 32'h83C);
    chk("wrap_x16",     rdata1, 32'h100F);
    chk("wrap_x1",      rdata2, 32'h1000);
    commit();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic        r, w, e1, e2;
      logic [4:0]  wa, a1, a2;
      r  = ($urandom_range(0, 39) == 0);
      w  = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      e1 = ($urandom_range(0, 4) != 0);
      e2 = ($urandom_range(0, 4) != 0);
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(r, w, wa, $urandom, $urandom, e1, a1, e2, a2);
      chk_model();
      commit();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
